// File: rtl/game_pkg.sv
// Shared types and helpers for the falling-block spawner: slot lifecycle states
// and the lane-to-X mapping.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    LOAD   = 2'd2,
    ACTIVE = 2'd3
  } slot_state_t;

  localparam int LANE_COUNT = 4;

  function automatic logic [9:0] lane_x(input logic [1:0] lane,
                                        input logic [9:0] base,
                                        input logic [9:0] step);
    return base + (10'(lane) * step);
  endfunction

endpackage

// File: rtl/spawn_slot.sv
// One managed block instance: lifecycle FSM, latched X centre, reset pulse and
// pause-gated ready.
module spawn_slot
  import game_pkg::*;
#(
  parameter int LANE_X_BASE = 200,
  parameter int Y_MAX       = 479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       game_enable,
  input  logic       alloc_i,
  input  logic [9:0] x_new_i,
  input  logic [9:0] y_i,
  output logic [9:0] x_o,
  output logic       reset_o,
  output logic       ready_o,
  output logic       idle_o
);

  slot_state_t state_q, state_d;
  logic [9:0]  x_q, x_d;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= 10'(LANE_X_BASE);
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

  // ARM and LOAD advance regardless of game_enable so a paused spawn still completes.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (alloc_i) begin
          state_d = ARM;
          x_d     = x_new_i;
        end
      end
      ARM:    state_d = LOAD;
      LOAD:   state_d = ACTIVE;
      ACTIVE: if (y_i > 10'(Y_MAX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign x_o     = x_q;
  assign reset_o = (state_q == LOAD);
  assign ready_o = (state_q == ACTIVE) && game_enable;
  assign idle_o  = (state_q == IDLE);

endmodule

// File: rtl/block_spawner.sv
// Playfield spawn scheduler: per-frame interval counter, LFSR lane picker and
// lowest-index-free slot allocator driving NUM_SLOTS block instances.
module block_spawner
  import game_pkg::*;
#(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_PERIOD = 60,
  parameter int          LANE_X_BASE  = 200,
  parameter int          LANE_X_STEP  = 80,
  parameter int          Y_MAX        = 479,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    game_enable,
  input  logic [10*NUM_SLOTS-1:0] slot_y,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [NUM_SLOTS-1:0]    slot_reset,
  output logic [NUM_SLOTS-1:0]    slot_ready,
  output logic [15:0]             spawn_count,
  output logic [7:0]              drop_count
);

  localparam int CNT_W = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;

  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [1:0]           last_lane_q, last_lane_d;
  logic [15:0]          spawn_cnt_q, spawn_cnt_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic                 spawn_edge;
  logic [1:0]           cand, lane;
  logic [9:0]           x_new;
  logic [NUM_SLOTS-1:0] idle, alloc;
  logic                 any_free;

  assign spawn_edge = game_enable && (frame_cnt_q == CNT_W'(SPAWN_PERIOD - 1));
  assign cand       = lfsr_q[1:0];
  assign lane       = (cand == last_lane_q) ? cand + 2'd1 : cand;
  assign x_new      = lane_x(lane, 10'(LANE_X_BASE), 10'(LANE_X_STEP));

  // Lowest-index IDLE slot wins; a slot leaving ACTIVE this edge is not yet IDLE.
  always_comb begin
    alloc    = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idle[i] && !any_free) begin
        alloc[i] = spawn_edge;
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    lfsr_d      = lfsr_q;
    last_lane_d = last_lane_q;
    spawn_cnt_d = spawn_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (spawn_edge) begin
      frame_cnt_d = '0;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      last_lane_d = lane;
      if (any_free)                spawn_cnt_d = spawn_cnt_q + 16'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (game_enable) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      frame_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      last_lane_q <= 2'd3;
      spawn_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
      last_lane_q <= last_lane_d;
      spawn_cnt_q <= spawn_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    spawn_slot #(
      .LANE_X_BASE(LANE_X_BASE),
      .Y_MAX      (Y_MAX)
    ) u_slot (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .game_enable(game_enable),
      .alloc_i    (alloc[g]),
      .x_new_i    (x_new),
      .y_i        (slot_y[10*g +: 10]),
      .x_o        (slot_x[10*g +: 10]),
      .reset_o    (slot_reset[g]),
      .ready_o    (slot_ready[g]),
      .idle_o     (idle[g])
    );
  end

  assign spawn_count = spawn_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_block_spawner.sv
// Randomized and directed bench for block_spawner against a frame-level
// behavioural model of slot ages, spawn timing and lane choice.
module tb_block_spawner;

  localparam int N = 4;
  localparam int P = 4;

  logic            frame_clk = 1'b0;
  logic            Reset;
  logic            game_enable;
  logic [10*N-1:0] slot_y;
  logic [10*N-1:0] slot_x;
  logic [N-1:0]    slot_reset;
  logic [N-1:0]    slot_ready;
  logic [15:0]     spawn_count;
  logic [7:0]      drop_count;

  block_spawner #(
    .NUM_SLOTS   (N),
    .SPAWN_PERIOD(P),
    .LANE_X_BASE (200),
    .LANE_X_STEP (80),
    .Y_MAX       (479),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .game_enable(game_enable),
    .slot_y     (slot_y),
    .slot_x     (slot_x),
    .slot_reset (slot_reset),
    .slot_ready (slot_ready),
    .spawn_count(spawn_count),
    .drop_count (drop_count)
  );

  always #5 frame_clk = ~frame_clk;

  // Model: age -1 = free, 0 = just allocated, 1 = reset frame, 2 = live.
  int          age [N];
  int          mx  [N];
  int          cnt;
  int          lf;
  int          last;
  int          sc;
  int          dc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          collisions = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int free_slot, cand, lane, fb;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin age[i] = -1; mx[i] = 200; end
      cnt = 0; lf = 'hACE1; last = 3; sc = 0; dc = 0;
      return;
    end
    free_slot = -1;
    for (int i = 0; i < N; i++) if (age[i] < 0 && free_slot < 0) free_slot = i;
    for (int i = 0; i < N; i++) begin
      if (age[i] >= 2 && int'(slot_y[10*i +: 10]) > 479) age[i] = -1;
      else if (age[i] >= 0 && age[i] < 2) age[i]++;
    end
    if (game_enable && cnt == P - 1) begin
      cand = lf % 4;
      if (cand == last) begin lane = (cand + 1) % 4; collisions++; end
      else lane = cand;
      last = lane;
      fb = ((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1;
      lf = ((lf << 1) & 'hFFFF) | fb;
      if (free_slot >= 0) begin
        age[free_slot] = 0;
        mx[free_slot]  = 200 + 80 * lane;
        sc = (sc + 1) % 65536;
      end else if (dc < 255) dc++;
      cnt = 0;
    end else if (game_enable) cnt++;
  endtask

  task automatic compare(input string tag);
    logic [10*N-1:0] ex;
    logic [N-1:0]    er, ed;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10] = 10'(mx[i]);
      er[i] = (age[i] == 1);
      ed[i] = (age[i] >= 2) && game_enable;
    end
    check_eq({tag, ".x"},     64'(slot_x),      64'(ex));
    check_eq({tag, ".rst"},   64'(slot_reset),  64'(er));
    check_eq({tag, ".rdy"},   64'(slot_ready),  64'(ed));
    check_eq({tag, ".spawn"}, 64'(spawn_count), 64'(sc));
    check_eq({tag, ".drop"},  64'(drop_count),  64'(dc));
  endtask

  task automatic step(input string tag);
    @(posedge frame_clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  initial begin
    int sc0;
    int guard;

    for (int i = 0; i < N; i++) begin age[i] = -1; mx[i] = 200; end
    cnt = 0; lf = 'hACE1; last = 3; sc = 0; dc = 0;
    Reset = 1'b1; game_enable = 1'b0; slot_y = '0;
    step("reset");
    step("reset");
    check_eq("reset_x0", 64'(slot_x[9:0]), 64'd200);
    check_eq("reset_rdy", 64'(slot_ready), 64'd0);
    Reset = 1'b0;

    // First spawn on the 4th enabled edge, seed low bits pick lane 1.
    game_enable = 1'b1;
    for (int k = 0; k < 4; k++) step("first");
    check_eq("first_x0", 64'(slot_x[9:0]), 64'd280);
    check_eq("first_cnt", 64'(spawn_count), 64'd1);
    for (int k = 0; k < 16; k++) step("fill");
    check_eq("fill_spawn", 64'(spawn_count), 64'd4);
    check_eq("fill_drop", 64'(drop_count), 64'd1);
    for (int k = 0; k < 260 * P; k++) step("sat");
    check_eq("sat_drop", 64'(drop_count), 64'd255);

    // Free slot0 exactly on a spawn edge; that spawn must not land in it.
    guard = 0;
    while (cnt != P - 1 && guard < 2 * P) begin step("align"); guard++; end
    check_eq("align_timeout", 64'(cnt), 64'(P - 1));
    sc0 = sc;
    slot_y[9:0] = 10'd480;
    step("exit");
    check_eq("exit_spawn", 64'(spawn_count), 64'(sc0));
    slot_y[9:0] = 10'd0;
    for (int k = 0; k < P; k++) step("reuse");
    check_eq("reuse_spawn", 64'(spawn_count), 64'(sc0 + 1));
    step("reuse"); step("reuse");

    // Pause gates ready at once; counter and LFSR hold for 10 frames.
    game_enable = 1'b0;
    #1;
    check_eq("pause_rdy", 64'(slot_ready), 64'd0);
    for (int k = 0; k < 10; k++) step("pause");
    game_enable = 1'b1;
    #1;
    check_eq("resume_rdy0", 64'(slot_ready[0]), 64'd1);

    // Reset while slot0 is in its reset-pulse frame.
    Reset = 1'b1; step("rst2"); Reset = 1'b0;
    guard = 0;
    while (age[0] != 1 && guard < 4 * P) begin step("to_load"); guard++; end
    check_eq("load_reached", 64'(slot_reset[0]), 64'd1);
    Reset = 1'b1;
    step("mid_rst");
    check_eq("mid_rst_pulse", 64'(slot_reset), 64'd0);
    check_eq("mid_rst_x", 64'(slot_x), {N{10'd200}});
    check_eq("mid_rst_cnt", 64'(spawn_count), 64'd0);
    Reset = 1'b0;

    // Randomized run: enable, exits and occasional resets.
    for (int k = 0; k < 5000; k++) begin
      game_enable = ($urandom_range(0, 9) != 0);
      Reset       = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++)
        slot_y[10*i +: 10] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(480, 1023))
                                                          : 10'($urandom_range(0, 479));
      step("rand");
    end
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
